// File: rtl/hazard_control_if.sv
// ID-stage decode bundle into the hazard controller and its control outputs back to the datapath.
// The decoder side is the master; the controller is the slave.
interface hazard_control_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_use_rn;
    logic             id_use_rm;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_setflag;
    logic             id_cbz;
    logic             id_blt;
    logic             id_brtaken;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic             bubble;
    logic             flush_if;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
               id_regwrite, id_memread, id_setflag, id_cbz, id_blt, id_brtaken,
        input  fwd_a, fwd_b, stall, bubble, flush_if, stall_count
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
               id_regwrite, id_memread, id_setflag, id_cbz, id_blt, id_brtaken,
        output fwd_a, fwd_b, stall, bubble, flush_if, stall_count
    );
endinterface

// File: rtl/hazard_control.sv
// LEGv8 hazard/forwarding controller: shadows EX/MEM/WB destination and control bits,
// drives EX operand forwarding, load-use/branch stalls, ID/EX bubbles and IF/ID squash.
module hazard_control #(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    hazard_control_if.slave hz
);
    localparam logic [4:0] XZR = 5'd31;

    logic [4:0]       ex_rn_q, ex_rn_d, ex_rm_q, ex_rm_d, ex_rd_q, ex_rd_d;
    logic             ex_use_rn_q, ex_use_rn_d, ex_use_rm_q, ex_use_rm_d;
    logic             ex_rw_q, ex_rw_d, ex_mr_q, ex_mr_d, ex_sf_q, ex_sf_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic             mem_rw_q, mem_rw_d, mem_mr_q, mem_mr_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_rw_q, wb_rw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use, cbz_hz, blt_hz, stall_w, issue;

    // EX/MEM beats MEM/WB; XZR never matches, and an operand not read in EX never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       use_src,
        input logic       m_rw,
        input logic [4:0] m_rd,
        input logic       w_rw,
        input logic [4:0] w_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && src != XZR) begin
            if (m_rw && m_rd == src)      sel = 2'b01;
            else if (w_rw && w_rd == src) sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = ex_mr_q && (ex_rd_q != XZR) &&
                   ((hz.id_use_rn && ex_rd_q == hz.id_rn) ||
                    (hz.id_use_rm && ex_rd_q == hz.id_rm));
        cbz_hz   = hz.id_cbz && (hz.id_rm != XZR) &&
                   ((ex_rw_q && ex_rd_q == hz.id_rm) ||
                    (mem_mr_q && mem_rd_q == hz.id_rm));
        blt_hz   = hz.id_blt && ex_sf_q;
        stall_w  = hz.id_valid && (load_use || cbz_hz || blt_hz);
        issue    = hz.id_valid && !stall_w;
    end

    always_comb begin
        ex_rn_d     = hz.id_rn;
        ex_rm_d     = hz.id_rm;
        ex_rd_d     = hz.id_rd;
        ex_use_rn_d = issue && hz.id_use_rn;
        ex_use_rm_d = issue && hz.id_use_rm;
        ex_rw_d     = issue && hz.id_regwrite;
        ex_mr_d     = issue && hz.id_memread;
        ex_sf_d     = issue && hz.id_setflag;
        mem_rd_d    = ex_rd_q;
        mem_rw_d    = ex_rw_q;
        mem_mr_d    = ex_mr_q;
        wb_rd_d     = mem_rd_q;
        wb_rw_d     = mem_rw_q;
        cnt_d       = cnt_q;
        if (stall_w && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rn_q     <= '0;
            ex_rm_q     <= '0;
            ex_rd_q     <= '0;
            ex_use_rn_q <= 1'b0;
            ex_use_rm_q <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_sf_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            mem_mr_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ex_rn_q     <= ex_rn_d;
            ex_rm_q     <= ex_rm_d;
            ex_rd_q     <= ex_rd_d;
            ex_use_rn_q <= ex_use_rn_d;
            ex_use_rm_q <= ex_use_rm_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            ex_sf_q     <= ex_sf_d;
            mem_rd_q    <= mem_rd_d;
            mem_rw_q    <= mem_rw_d;
            mem_mr_q    <= mem_mr_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hz.fwd_a       = fwd_sel(ex_rn_q, ex_use_rn_q, mem_rw_q, mem_rd_q, wb_rw_q, wb_rd_q);
    assign hz.fwd_b       = fwd_sel(ex_rm_q, ex_use_rm_q, mem_rw_q, mem_rd_q, wb_rw_q, wb_rd_q);
    assign hz.stall       = stall_w;
    assign hz.bubble      = stall_w;
    // A stalled branch re-resolves next cycle, so its taken signal is ignored now.
    assign hz.flush_if    = hz.id_valid && hz.id_brtaken && !stall_w;
    assign hz.stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: directed LEGv8 hazard sequences plus random instruction streams,
// checked against an instruction-history model; a CNT_W=2 copy exercises counter saturation.
module tb_hazard_control;
  logic clk;
  logic reset;

  hazard_control_if #(.CNT_W(16)) hz ();
  hazard_control_if #(.CNT_W(2))  hz2 ();

  hazard_control #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .hz(hz));
  hazard_control #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .hz(hz2));

  assign hz2.id_valid    = hz.id_valid;
  assign hz2.id_rn       = hz.id_rn;
  assign hz2.id_rm       = hz.id_rm;
  assign hz2.id_use_rn   = hz.id_use_rn;
  assign hz2.id_use_rm   = hz.id_use_rm;
  assign hz2.id_rd       = hz.id_rd;
  assign hz2.id_regwrite = hz.id_regwrite;
  assign hz2.id_memread  = hz.id_memread;
  assign hz2.id_setflag  = hz.id_setflag;
  assign hz2.id_cbz      = hz.id_cbz;
  assign hz2.id_blt      = hz.id_blt;
  assign hz2.id_brtaken  = hz.id_brtaken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rn, rm, rd;
    logic       use_rn, use_rm, rw, mr, sf, cbz, blt, taken;
  } id_t;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        stall, flush;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t exp_q[$];
  id_t  hist[$];  // hist[0] is in EX, hist[1] in MEM, hist[2] in WB
  int   m_cnt, m_cnt2;
  logic m_last_stall;
  int   n_checks, n_pass;
  logic [1:0]  last_fa, last_fb;
  logic        last_stall, last_flush;
  logic [15:0] last_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic id_t nop();
    id_t n = '0;
    return n;
  endfunction

  function automatic id_t alu(input int rd, input int rn, input int rm, input bit sf, input bit use_rm);
    id_t n = '0;
    n.valid = 1; n.rd = 5'(rd); n.rn = 5'(rn); n.rm = 5'(rm);
    n.use_rn = 1; n.use_rm = use_rm; n.rw = 1; n.sf = sf;
    return n;
  endfunction

  function automatic id_t ldur(input int rd, input int rn);
    id_t n = '0;
    n.valid = 1; n.rd = 5'(rd); n.rn = 5'(rn); n.use_rn = 1; n.rw = 1; n.mr = 1;
    return n;
  endfunction

  function automatic id_t cbz(input int rt, input bit taken);
    id_t n = '0;
    n.valid = 1; n.rm = 5'(rt); n.cbz = 1; n.taken = taken;
    return n;
  endfunction

  function automatic id_t blt(input bit taken);
    id_t n = '0;
    n.valid = 1; n.rn = 5'd31; n.rm = 5'd31; n.blt = 1; n.taken = taken;
    return n;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src, input logic use_src);
    if (!use_src || src == 5'd31) return 2'd0;
    if (hist[1].rw && hist[1].rd == src) return 2'd1;
    if (hist[2].rw && hist[2].rd == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic model_stall(input id_t d);
    logic lu, cb, bl;
    lu = hist[0].mr && hist[0].rd != 5'd31 &&
         ((d.use_rn && hist[0].rd == d.rn) || (d.use_rm && hist[0].rd == d.rm));
    cb = d.cbz && d.rm != 5'd31 &&
         ((hist[0].rw && hist[0].rd == d.rm) || (hist[1].mr && hist[1].rd == d.rm));
    bl = d.blt && hist[0].sf;
    return d.valid && (lu || cb || bl);
  endfunction

  task automatic drive(input id_t d);
    hz.id_valid = d.valid;   hz.id_rn = d.rn;         hz.id_rm = d.rm;
    hz.id_use_rn = d.use_rn; hz.id_use_rm = d.use_rm; hz.id_rd = d.rd;
    hz.id_regwrite = d.rw;   hz.id_memread = d.mr;    hz.id_setflag = d.sf;
    hz.id_cbz = d.cbz;       hz.id_blt = d.blt;       hz.id_brtaken = d.taken;
  endtask

  function automatic id_t rand_id();
    id_t n;
    int k;
    int r[3];
    for (int i = 0; i < 3; i++) begin
      r[i] = $urandom_range(0, 6);
      if (r[i] == 6) r[i] = 31;
    end
    k = $urandom_range(0, 5);
    case (k)
      0, 1: n = alu(r[0], r[1], r[2], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      2:    n = ldur(r[0], r[1]);
      3:    n = cbz(r[2], 1'($urandom_range(0, 1)));
      4:    n = blt(1'($urandom_range(0, 1)));
      default: begin
        n = alu(r[0], r[1], r[2], 1'b0, 1'b1);
        n.rw = 0;
      end
    endcase
    if ($urandom_range(0, 9) == 0) n.valid = 0;
    return n;
  endfunction

  task automatic model_clear();
    hist.delete();
    repeat (3) hist.push_back(nop());
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  // One ID cycle: drive, predict, let the monitor compare at negedge, then advance the model.
  task automatic step(input id_t d);
    exp_t e;
    logic st;
    drive(d);
    st      = model_stall(d);
    e.fa    = model_fwd(hist[0].rn, hist[0].use_rn);
    e.fb    = model_fwd(hist[0].rm, hist[0].use_rm);
    e.stall = st;
    e.flush = d.valid && d.taken && !st;
    e.cnt   = m_cnt[15:0];
    e.cnt2  = m_cnt2[1:0];
    exp_q.push_back(e);
    m_last_stall = st;
    #2;
    last_fa = hz.fwd_a; last_fb = hz.fwd_b;
    last_stall = hz.stall; last_flush = hz.flush_if; last_cnt = hz.stall_count;
    @(posedge clk);
    hist.push_front((d.valid && !st) ? d : nop());
    void'(hist.pop_back());
    if (st) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    #1;
  endtask

  // Present d until it issues; returns how many of those cycles the DUT stalled.
  task automatic issue(input id_t d, output int n_stall);
    n_stall = 0;
    for (int i = 0; i < 8; i++) begin
      step(d);
      if (last_stall) n_stall++;
      if (!m_last_stall) break;
    end
    if (m_last_stall) begin
      n_checks++;
      $display("FAIL issue_bound: instruction still stalled after 8 cycles");
    end
  endtask

  task automatic drain();
    repeat (3) step(nop());
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    drive(rand_id());
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      drive(rand_id());
    end
    reset = 1'b0;
    model_clear();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("fwd_a", 32'(hz.fwd_a), 32'(e.fa));
      check("fwd_b", 32'(hz.fwd_b), 32'(e.fb));
      check("stall", 32'(hz.stall), 32'(e.stall));
      check("bubble", 32'(hz.bubble), 32'(e.stall));
      check("flush_if", 32'(hz.flush_if), 32'(e.flush));
      check("stall_count", 32'(hz.stall_count), 32'(e.cnt));
      check("stall_count_w2", 32'(hz2.stall_count), 32'(e.cnt2));
    end
  end

  initial begin
    int ns;
    id_t cur;
    n_checks = 0;
    n_pass = 0;
    model_clear();

    do_reset(2);
    step(nop());
    check("rst_fwd_a", 32'(last_fa), 0);
    check("rst_fwd_b", 32'(last_fb), 0);
    check("rst_stall", 32'(last_stall), 0);
    check("rst_flush", 32'(last_flush), 0);
    check("rst_count", 32'(last_cnt), 0);

    // ADDS X5,X3,X4 ; SUBS X1,X5,X5
    issue(alu(5, 3, 4, 1, 1), ns);
    issue(alu(1, 5, 5, 1, 1), ns);
    check("adjacent_nostall", ns, 0);
    step(nop());
    check("adjacent_fwd_a", 32'(last_fa), 1);
    check("adjacent_fwd_b", 32'(last_fb), 1);
    drain();

    issue(alu(5, 3, 4, 1, 1), ns);
    issue(alu(9, 7, 8, 0, 1), ns);
    issue(alu(1, 5, 5, 1, 1), ns);
    check("gap_nostall", ns, 0);
    step(nop());
    check("gap_fwd_a", 32'(last_fa), 2);
    check("gap_fwd_b", 32'(last_fb), 2);
    drain();

    // LDUR X2,[X0] ; ADD X3,X2,X1
    issue(ldur(2, 0), ns);
    issue(alu(3, 2, 1, 0, 1), ns);
    check("loaduse_stalls", ns, 1);
    step(nop());
    check("loaduse_fwd_a", 32'(last_fa), 2);
    check("loaduse_count", 32'(last_cnt), 1);
    drain();

    issue(ldur(4, 0), ns);
    issue(cbz(4, 1), ns);
    check("ldur_cbz_stalls", ns, 2);
    check("ldur_cbz_flush", 32'(last_flush), 1);
    drain();
    issue(alu(4, 4, 0, 0, 0), ns);
    issue(cbz(4, 0), ns);
    check("alu_cbz_stalls", ns, 1);
    drain();

    issue(alu(31, 1, 2, 1, 1), ns);
    issue(alu(6, 31, 31, 0, 1), ns);
    check("xzr_nostall", ns, 0);
    step(nop());
    check("xzr_fwd_a", 32'(last_fa), 0);
    check("xzr_fwd_b", 32'(last_fb), 0);
    issue(ldur(31, 0), ns);
    issue(alu(6, 31, 31, 0, 1), ns);
    check("xzr_load_nostall", ns, 0);
    drain();

    issue(alu(1, 2, 3, 1, 1), ns);
    step(blt(1));
    check("blt_c1_stall", 32'(last_stall), 1);
    check("blt_c1_flush", 32'(last_flush), 0);
    step(blt(1));
    check("blt_c2_stall", 32'(last_stall), 0);
    check("blt_c2_flush", 32'(last_flush), 1);
    drain();

    // Load-use and taken branch in the same cycle
    issue(ldur(2, 0), ns);
    cur = alu(3, 2, 1, 0, 1);
    cur.taken = 1;
    step(cur);
    check("lu_br_stall", 32'(last_stall), 1);
    check("lu_br_flush", 32'(last_flush), 0);
    step(cur);
    check("lu_br_flush_next", 32'(last_flush), 1);
    drain();

    // Reset while a load-use stall is in progress
    issue(ldur(2, 0), ns);
    step(alu(3, 2, 1, 0, 1));
    do_reset(1);
    step(nop());
    check("midrst_stall", 32'(last_stall), 0);
    check("midrst_count", 32'(last_cnt), 0);
    issue(alu(3, 2, 1, 0, 1), ns);
    check("midrst_nostall", ns, 0);

    cur = rand_id();
    for (int i = 0; i < 600; i++) begin
      step(cur);
      if (!m_last_stall) cur = rand_id();
    end
    drain();
    @(negedge clk);
    #1;
    check("cnt_w2_saturated", 32'(hz2.stall_count), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
